// File: rtl/serial_sub_pkg.sv
// Shared constants and FSM encoding for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor built from two half subtractors and an OR of their borrows.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Diff,
    output logic Borrow
);

    logic d1;
    logic bo1;
    logic bo2;

    half_subtractor u_hs_ab (
        .A      (A),
        .B      (B),
        .Diff   (d1),
        .Borrow (bo1)
    );

    half_subtractor u_hs_bin (
        .A      (d1),
        .B      (Bin),
        .Diff   (Diff),
        .Borrow (bo2)
    );

    assign Borrow = bo1 | bo2;

endmodule

// File: rtl/half_subtractor.sv
// One-bit half subtractor: Diff = A - B, Borrow when B exceeds A.
module half_subtractor (
    input  logic A,
    input  logic B,
    output logic Diff,
    output logic Borrow
);

    assign Diff   = A ^ B;
    assign Borrow = ~A & B;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB-first, one bit per clock.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             busy_q;
    logic             done_q;
    logic             fs_diff;
    logic             fs_borrow;

    full_subtractor u_fs (
        .A      (a_q[0]),
        .B      (b_q[0]),
        .Bin    (br_q),
        .Diff   (fs_diff),
        .Borrow (fs_borrow)
    );

    // Next-state: load on accept, shift one bit per SHIFT cycle, publish on last bit.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_d = {fs_diff, res_q[WIDTH-1:1]};
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                br_d  = fs_borrow;
                // Counter holds on the final bit so it never wraps.
                if (cnt_q == LAST_BIT) begin
                    diff_d  = res_d;
                    bout_d  = fs_borrow;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule
